// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single memory port: D-side priority with a starvation
// counter for the I-side, plus a per-tag owner table that routes load completions back.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2Imem_command,
    input  logic [XLEN-1:0] proc2Imem_addr,
    input  logic [1:0]      proc2Dmem_command,
    input  logic [XLEN-1:0] proc2Dmem_addr,
    input  logic [63:0]     proc2Dmem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [3:0]      Imem2proc_response,
    output logic [3:0]      Imem2proc_tag,
    output logic [63:0]     Imem2proc_data,
    output logic [3:0]      Dmem2proc_response,
    output logic [3:0]      Dmem2proc_tag,
    output logic [63:0]     Dmem2proc_data,
    output logic            grant_i
);

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [3:0] MAX_TAG   = 4'(NUM_TAGS);

    logic       valid_q [1:NUM_TAGS];
    logic       valid_d [1:NUM_TAGS];
    logic       owner_q [1:NUM_TAGS];   // 0 = I-side, 1 = D-side
    logic       owner_d [1:NUM_TAGS];
    logic [3:0] starve_q, starve_d;
    logic       i_prio_q, i_prio_d;

    logic i_req, d_req, grant_d, accepted, load_accept;
    logic hit_valid, hit_owner, cpl_valid;

    // Requests are masked during reset so nothing reaches memory or the requesters.
    always_comb begin
        i_req       = !reset && (proc2Imem_command == CMD_LOAD);
        d_req       = !reset && ((proc2Dmem_command == CMD_LOAD) || (proc2Dmem_command == CMD_STORE));
        grant_i     = i_req && (!d_req || i_prio_q);
        grant_d     = d_req && !grant_i;
        accepted    = (mem2proc_response != 4'd0) && (mem2proc_response <= MAX_TAG) && (grant_i || grant_d);
        load_accept = accepted && (proc2mem_command == CMD_LOAD);
    end

    always_comb begin
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_i) begin
            proc2mem_command = CMD_LOAD;
            proc2mem_addr    = proc2Imem_addr;
        end else if (grant_d) begin
            proc2mem_command = proc2Dmem_command;
            proc2mem_addr    = proc2Dmem_addr;
            proc2mem_data    = proc2Dmem_data;
        end
        Imem2proc_response = grant_i ? mem2proc_response : 4'd0;
        Dmem2proc_response = grant_d ? mem2proc_response : 4'd0;
    end

    // Completion lookup always uses the pre-edge table contents.
    always_comb begin
        hit_valid = 1'b0;
        hit_owner = 1'b0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (mem2proc_tag == 4'(i)) begin
                hit_valid = valid_q[i];
                hit_owner = owner_q[i];
            end
        end
        cpl_valid = !reset && (mem2proc_tag != 4'd0) && hit_valid;
    end

    always_comb begin
        Imem2proc_tag  = 4'd0;
        Imem2proc_data = '0;
        Dmem2proc_tag  = 4'd0;
        Dmem2proc_data = '0;
        if (cpl_valid && !hit_owner) begin
            Imem2proc_tag  = mem2proc_tag;
            Imem2proc_data = mem2proc_data;
        end else if (cpl_valid && hit_owner) begin
            Dmem2proc_tag  = mem2proc_tag;
            Dmem2proc_data = mem2proc_data;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= NUM_TAGS; gi++) begin : g_entry
            // A new acceptance of this tag overrides a same-cycle completion clear.
            always_comb begin
                valid_d[gi] = valid_q[gi];
                owner_d[gi] = owner_q[gi];
                if (cpl_valid && (mem2proc_tag == 4'(gi))) begin
                    valid_d[gi] = 1'b0;
                end
                if (load_accept && (mem2proc_response == 4'(gi))) begin
                    valid_d[gi] = 1'b1;
                    owner_d[gi] = grant_d;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_q[gi] <= 1'b0;
                    owner_q[gi] <= 1'b0;
                end else begin
                    valid_q[gi] <= valid_d[gi];
                    owner_q[gi] <= owner_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        starve_d = starve_q;
        i_prio_d = i_prio_q;
        if (accepted && grant_i) begin
            starve_d = 4'd0;
            i_prio_d = 1'b0;
        end else if (accepted && grant_d && i_req) begin
            if (starve_q >= LIMIT - 4'd1) begin
                starve_d = LIMIT;
                i_prio_d = 1'b1;
            end else begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= 4'd0;
            i_prio_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            i_prio_q <= i_prio_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant/acceptance routing, starvation, owner table, reset.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  proc2Imem_command;
    logic [31:0] proc2Imem_addr;
    logic [1:0]  proc2Dmem_command;
    logic [31:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  Imem2proc_response, Imem2proc_tag, Dmem2proc_response, Dmem2proc_tag;
    logic [63:0] Imem2proc_data, Dmem2proc_data;
    logic        grant_i;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .NUM_TAGS(15)) dut (
        .clock(clock), .reset(reset),
        .proc2Imem_command(proc2Imem_command), .proc2Imem_addr(proc2Imem_addr),
        .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
        .proc2Dmem_data(proc2Dmem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .Imem2proc_response(Imem2proc_response), .Imem2proc_tag(Imem2proc_tag),
        .Imem2proc_data(Imem2proc_data),
        .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_tag(Dmem2proc_tag),
        .Dmem2proc_data(Dmem2proc_data),
        .grant_i(grant_i)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        proc2Imem_command = 2'd0; proc2Imem_addr = '0;
        proc2Dmem_command = 2'd0; proc2Dmem_addr = '0; proc2Dmem_data = '0;
        mem2proc_response = 4'd0; mem2proc_data = '0; mem2proc_tag = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        proc2Imem_command = 2'd1; proc2Imem_addr = 32'h100;
        proc2Dmem_command = 2'd1; mem2proc_response = 4'd3; mem2proc_tag = 4'd3;
        #1;
        n_checks++; if (proc2mem_command !== 2'd0) begin n_fail++; $display("FAIL rst_cmd got=%0d exp=0", proc2mem_command); end
        n_checks++; if (Imem2proc_response !== 4'd0) begin n_fail++; $display("FAIL rst_iresp got=%0d exp=0", Imem2proc_response); end
        n_checks++; if (Dmem2proc_response !== 4'd0) begin n_fail++; $display("FAIL rst_dresp got=%0d exp=0", Dmem2proc_response); end
        n_checks++; if (Imem2proc_tag !== 4'd0 || Dmem2proc_tag !== 4'd0) begin n_fail++; $display("FAIL rst_tags got=%0d/%0d exp=0/0", Imem2proc_tag, Dmem2proc_tag); end
        tick();
        reset = 1'b0;
        idle();
        #1;
        n_checks++; if (grant_i !== 1'b0 || proc2mem_command !== 2'd0) begin n_fail++; $display("FAIL idle_grant got=%0b/%0d exp=0/0", grant_i, proc2mem_command); end
        tick();
    endtask

    task automatic test_i_load();
        proc2Imem_command = 2'd1; proc2Imem_addr = 32'h100; mem2proc_response = 4'd3;
        #1;
        n_checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h100) begin n_fail++; $display("FAIL i_fwd got=%0d/%h exp=1/100", proc2mem_command, proc2mem_addr); end
        n_checks++; if (proc2mem_data !== 64'd0) begin n_fail++; $display("FAIL i_data0 got=%h exp=0", proc2mem_data); end
        n_checks++; if (Imem2proc_response !== 4'd3 || Dmem2proc_response !== 4'd0) begin n_fail++; $display("FAIL i_resp got=%0d/%0d exp=3/0", Imem2proc_response, Dmem2proc_response); end
        n_checks++; if (grant_i !== 1'b1) begin n_fail++; $display("FAIL i_grant got=%0b exp=1", grant_i); end
        tick();
        idle();
        tick();
        mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD;
        #1;
        n_checks++; if (Imem2proc_tag !== 4'd3 || Imem2proc_data !== 64'hDEAD) begin n_fail++; $display("FAIL i_cpl got=%0d/%h exp=3/dead", Imem2proc_tag, Imem2proc_data); end
        n_checks++; if (Dmem2proc_tag !== 4'd0) begin n_fail++; $display("FAIL i_cpl_d got=%0d exp=0", Dmem2proc_tag); end
        tick();
        #1;
        n_checks++; if (Imem2proc_tag !== 4'd0) begin n_fail++; $display("FAIL i_cpl_clear got=%0d exp=0", Imem2proc_tag); end
        idle();
        tick();
    endtask

    task automatic test_starve();
        proc2Imem_command = 2'd1; proc2Imem_addr = 32'h200;
        proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            mem2proc_response = 4'(k + 1);
            #1;
            n_checks++; if (grant_i !== 1'b0 || Dmem2proc_response !== 4'(k + 1) || Imem2proc_response !== 4'd0)
                begin n_fail++; $display("FAIL starve_d%0d got=%0b/%0d/%0d exp=0/%0d/0", k, grant_i, Dmem2proc_response, Imem2proc_response, k + 1); end
            tick();
        end
        mem2proc_response = 4'd5;
        #1;
        n_checks++; if (grant_i !== 1'b1 || proc2mem_addr !== 32'h200 || Imem2proc_response !== 4'd5)
            begin n_fail++; $display("FAIL starve_i got=%0b/%h/%0d exp=1/200/5", grant_i, proc2mem_addr, Imem2proc_response); end
        tick();
    endtask

    task automatic test_prio_hold();
        // Four fresh D wins are required again, showing the counter restarted at 0.
        for (int k = 0; k < 4; k++) begin
            mem2proc_response = 4'(k + 8);
            #1;
            n_checks++; if (grant_i !== 1'b0 || Dmem2proc_response !== 4'(k + 8))
                begin n_fail++; $display("FAIL hold_d%0d got=%0b/%0d exp=0/%0d", k, grant_i, Dmem2proc_response, k + 8); end
            tick();
        end
        mem2proc_response = 4'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (grant_i !== 1'b1 || Dmem2proc_response !== 4'd0 || Imem2proc_response !== 4'd0)
                begin n_fail++; $display("FAIL hold_busy%0d got=%0b/%0d exp=1/0", k, grant_i, Dmem2proc_response); end
            tick();
        end
        mem2proc_response = 4'd7;
        #1;
        n_checks++; if (grant_i !== 1'b1 || Imem2proc_response !== 4'd7) begin n_fail++; $display("FAIL hold_acc got=%0b/%0d exp=1/7", grant_i, Imem2proc_response); end
        tick();
        mem2proc_response = 4'd12;
        #1;
        n_checks++; if (grant_i !== 1'b0 || Dmem2proc_response !== 4'd12) begin n_fail++; $display("FAIL hold_after got=%0b/%0d exp=0/12", grant_i, Dmem2proc_response); end
        tick();
        idle();
    endtask

    task automatic test_drain();
        logic [3:0] tags  [11];
        logic       owner [11];
        tags  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
        owner = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 11; k++) begin
            mem2proc_tag = tags[k]; mem2proc_data = 64'h1000 + 64'(tags[k]);
            #1;
            if (owner[k]) begin
                n_checks++; if (Dmem2proc_tag !== tags[k] || Imem2proc_tag !== 4'd0 || Dmem2proc_data !== 64'h1000 + 64'(tags[k]))
                    begin n_fail++; $display("FAIL drain_t%0d got=I%0d/D%0d exp=I0/D%0d", tags[k], Imem2proc_tag, Dmem2proc_tag, tags[k]); end
            end else begin
                n_checks++; if (Imem2proc_tag !== tags[k] || Dmem2proc_tag !== 4'd0 || Imem2proc_data !== 64'h1000 + 64'(tags[k]))
                    begin n_fail++; $display("FAIL drain_t%0d got=I%0d/D%0d exp=I%0d/D0", tags[k], Imem2proc_tag, Dmem2proc_tag, tags[k]); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_store();
        proc2Dmem_command = 2'd2; proc2Dmem_addr = 32'h810; proc2Dmem_data = 64'hABCD_0110_1001_ABCD;
        mem2proc_response = 4'd5;
        #1;
        n_checks++; if (proc2mem_command !== 2'd2 || proc2mem_addr !== 32'h810 || proc2mem_data !== 64'hABCD_0110_1001_ABCD)
            begin n_fail++; $display("FAIL st_fwd got=%0d/%h/%h exp=2/810/abcd01101001abcd", proc2mem_command, proc2mem_addr, proc2mem_data); end
        n_checks++; if (Dmem2proc_response !== 4'd5) begin n_fail++; $display("FAIL st_resp got=%0d exp=5", Dmem2proc_response); end
        tick();
        idle();
        mem2proc_tag = 4'd5;
        #1;
        n_checks++; if (Imem2proc_tag !== 4'd0 || Dmem2proc_tag !== 4'd0) begin n_fail++; $display("FAIL st_stray got=%0d/%0d exp=0/0", Imem2proc_tag, Dmem2proc_tag); end
        tick();
        idle();
    endtask

    task automatic test_same_cycle();
        proc2Imem_command = 2'd1; mem2proc_response = 4'd2;
        tick();
        idle();
        proc2Dmem_command = 2'd1; mem2proc_response = 4'd2; mem2proc_tag = 4'd2; mem2proc_data = 64'h1111;
        #1;
        n_checks++; if (Imem2proc_tag !== 4'd2 || Imem2proc_data !== 64'h1111 || Dmem2proc_tag !== 4'd0)
            begin n_fail++; $display("FAIL same_old got=I%0d/D%0d exp=I2/D0", Imem2proc_tag, Dmem2proc_tag); end
        n_checks++; if (Dmem2proc_response !== 4'd2) begin n_fail++; $display("FAIL same_acc got=%0d exp=2", Dmem2proc_response); end
        tick();
        idle();
        mem2proc_tag = 4'd2; mem2proc_data = 64'h2222;
        #1;
        n_checks++; if (Dmem2proc_tag !== 4'd2 || Dmem2proc_data !== 64'h2222 || Imem2proc_tag !== 4'd0)
            begin n_fail++; $display("FAIL same_new got=I%0d/D%0d exp=I0/D2", Imem2proc_tag, Dmem2proc_tag); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        proc2Imem_command = 2'd1; mem2proc_response = 4'd1;
        tick();
        idle(); proc2Dmem_command = 2'd1; mem2proc_response = 4'd2;
        tick();
        idle(); proc2Imem_command = 2'd1; mem2proc_response = 4'd3;
        tick();
        idle();
        reset = 1'b1;
        proc2Dmem_command = 2'd1; mem2proc_response = 4'd4; mem2proc_tag = 4'd1; mem2proc_data = 64'h55;
        #1;
        n_checks++; if (proc2mem_command !== 2'd0 || Dmem2proc_response !== 4'd0 || Imem2proc_tag !== 4'd0)
            begin n_fail++; $display("FAIL mrst_out got=%0d/%0d/%0d exp=0/0/0", proc2mem_command, Dmem2proc_response, Imem2proc_tag); end
        tick();
        tick();
        reset = 1'b0;
        idle();
        for (int k = 1; k <= 4; k++) begin
            mem2proc_tag = 4'(k); mem2proc_data = 64'h77;
            #1;
            n_checks++; if (Imem2proc_tag !== 4'd0 || Dmem2proc_tag !== 4'd0)
                begin n_fail++; $display("FAIL mrst_stray%0d got=%0d/%0d exp=0/0", k, Imem2proc_tag, Dmem2proc_tag); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_i_load();
        test_starve();
        test_prio_hold();
        test_drain();
        test_store();
        test_same_cycle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
